// File: rtl/counter8_seq_if.sv
// -----------------------------------------------------------------------------
// counter8_seq_if
// Bundles the command, configuration and status signals between the
// button/switch front-end (master) and the run/pause/step sequencer (slave).
//
// Signal semantics: there is no valid/ready pair on this bus. start_p, stop_p,
// step_p and clear_p are single-cycle command pulses sampled on the rising
// clock edge. rate_sel, dir, mode_wrap and limit are level controls sampled
// every cycle. q, tick, state and done are registered status from the
// sequencer.
//
//   start_p   : start or resume counting
//   stop_p    : pause counting
//   step_p    : single manual step (IDLE/PAUSE only)
//   clear_p   : return to IDLE and reload the start value
//   rate_sel  : 00=1 Hz, 01=2 Hz, 10=4 Hz, 11=8 Hz
//   dir       : 1=count up, 0=count down
//   mode_wrap : 1=wrap at end value, 0=stop at end value
//   limit     : terminal value (up) / reload value (down)
//   q         : current count
//   tick      : high in the cycle a step is applied to q
//   state     : 00=IDLE, 01=RUN, 10=PAUSE, 11=DONE
//   done      : high while state==DONE
// -----------------------------------------------------------------------------
interface counter8_seq_if;
    logic       start_p;
    logic       stop_p;
    logic       step_p;
    logic       clear_p;
    logic [1:0] rate_sel;
    logic       dir;
    logic       mode_wrap;
    logic [7:0] limit;
    logic [7:0] q;
    logic       tick;
    logic [1:0] state;
    logic       done;

    modport master (
        output start_p, stop_p, step_p, clear_p, rate_sel, dir, mode_wrap, limit,
        input  q, tick, state, done
    );

    modport slave (
        input  start_p, stop_p, step_p, clear_p, rate_sel, dir, mode_wrap, limit,
        output q, tick, state, done
    );
endinterface

// File: rtl/counter8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter8_seq_ctrl
// Run/pause/step sequencer for the 8-bit display counter. Owns the prescaler
// and the count register; supports wrap-around or stop-at-limit operation.
//
// Ports:
//   clk   : system clock, all logic on rising edge
//   rst_n : asynchronous reset, active low
//   bus   : counter8_seq_if.slave -- command pulses, rate/dir/wrap/limit
//           controls in; q, tick, state, done out (all registered)
//
// Parameter:
//   F_CLK_HZ : system clock frequency in Hz (>= 8, divisible by 8)
// -----------------------------------------------------------------------------
module counter8_seq_ctrl #(
    parameter int unsigned F_CLK_HZ = 50_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    counter8_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t      state_r;
    logic [7:0]  q_r;
    logic        tick_r;
    logic        done_r;
    logic [31:0] presc_r;

    // Cycles per step: the clock divided by 1, 2, 4 or 8 steps per second.
    logic [31:0] period;
    always_comb begin
        case (bus.rate_sel)
            2'b00:   period = F_CLK_HZ;
            2'b01:   period = F_CLK_HZ >> 1;
            2'b10:   period = F_CLK_HZ >> 2;
            default: period = F_CLK_HZ >> 3;
        endcase
    end

    logic [7:0] start_val;
    assign start_val = bus.dir ? 8'd0 : bus.limit;

    // Result of one step event evaluated on the registered count.
    // q above limit is treated as being at the limit.
    logic [7:0] step_q;
    logic       step_tick;
    logic       step_done;
    always_comb begin
        step_q    = q_r;
        step_tick = 1'b0;
        step_done = 1'b0;
        if (bus.dir) begin
            if (q_r < bus.limit) begin
                step_q    = q_r + 8'd1;
                step_tick = 1'b1;
                step_done = !bus.mode_wrap && (step_q == bus.limit);
            end else if (bus.mode_wrap) begin
                step_q    = 8'd0;
                step_tick = 1'b1;
            end else begin
                step_done = 1'b1;
            end
        end else begin
            if (q_r != 8'd0) begin
                step_q    = q_r - 8'd1;
                step_tick = 1'b1;
                step_done = !bus.mode_wrap && (step_q == 8'd0);
            end else if (bus.mode_wrap) begin
                step_q    = bus.limit;
                step_tick = 1'b1;
            end else begin
                step_done = 1'b1;
            end
        end
    end

    // Command priority: clear_p > stop_p > start_p > step_p. A higher-priority
    // pulse that has no effect in the current state still masks the lower ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            q_r     <= 8'd0;
            tick_r  <= 1'b0;
            done_r  <= 1'b0;
            presc_r <= 32'd0;
        end else begin
            tick_r <= 1'b0;
            if (bus.clear_p) begin
                state_r <= ST_IDLE;
                q_r     <= start_val;
                done_r  <= 1'b0;
                presc_r <= 32'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        presc_r <= 32'd0;
                        if (bus.stop_p) begin
                            // nothing to pause; masks start/step
                        end else if (bus.start_p) begin
                            state_r <= ST_RUN;
                        end else if (bus.step_p) begin
                            q_r    <= step_q;
                            tick_r <= step_tick;
                            if (step_done) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (bus.stop_p) begin
                            state_r <= ST_PAUSE;
                        end else if (presc_r >= period - 32'd1) begin
                            // >= keeps a shorter period selected mid-count safe
                            presc_r <= 32'd0;
                            q_r     <= step_q;
                            tick_r  <= step_tick;
                            if (step_done) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end
                        end else begin
                            presc_r <= presc_r + 32'd1;
                        end
                    end
                    ST_PAUSE: begin
                        if (bus.stop_p) begin
                            // already paused
                        end else if (bus.start_p) begin
                            // prescaler resumes from its held value
                            state_r <= ST_RUN;
                        end else if (bus.step_p) begin
                            q_r    <= step_q;
                            tick_r <= step_tick;
                            if (step_done) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end
                        end
                    end
                    default: begin // ST_DONE
                        presc_r <= 32'd0;
                        if (bus.stop_p) begin
                            // ignored; masks start
                        end else if (bus.start_p) begin
                            state_r <= ST_RUN;
                            q_r     <= start_val;
                            done_r  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.q     = q_r;
    assign bus.tick  = tick_r;
    assign bus.state = state_r;
    assign bus.done  = done_r;

endmodule
